// File: rtl/cmp_sort_pkg.sv
// Shared types and constants for the compare-sort sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cmp_sort_pkg;

    localparam int DATA_W = 4;
    localparam int N_MAX  = 16;

    // IDLE/LOAD accept words, SORT runs bubble passes, DRAIN streams results
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SORT  = 2'd2,
        DRAIN = 2'd3
    } sort_state_t;

endpackage

// File: rtl/cmp_sort_ctrl_comparator.sv
// 4-bit unsigned magnitude comparator; exactly one output is high.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module comparator (
    input  logic [3:0] Data_in_A,
    input  logic [3:0] Data_in_B,
    output logic       less,
    output logic       equal,
    output logic       greater
);

    assign less    = (Data_in_A <  Data_in_B);
    assign equal   = (Data_in_A == Data_in_B);
    assign greater = (Data_in_A >  Data_in_B);

endmodule

// File: rtl/cmp_sort_ctrl.sv
// Loads N 4-bit words, bubble-sorts them in place on one shared comparator, streams them out ascending.
// Latency: N load cycles, N-1 .. N(N-1)/2 compare cycles, N drain cycles at full throughput.
// Backpressure: in_ready low outside IDLE/LOAD; out_data/out_last hold while out_ready is low.
module cmp_sort_ctrl
    import cmp_sort_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = $clog2(N*(N-1)/2+1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic [CW-1:0]     swap_cnt
);

    localparam int            IW       = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N-1);
    localparam logic [IW-1:0] LAST_J   = IW'(N-2);

    sort_state_t       state;
    logic [DATA_W-1:0] slot [N];
    logic [IW-1:0]     wi;
    logic [IW-1:0]     ri;
    logic [IW-1:0]     j;
    logic [IW-1:0]     p;
    logic              swapped;

    logic [IW-1:0]     j_nxt;
    logic [DATA_W-1:0] cmp_a;
    logic [DATA_W-1:0] cmp_b;
    logic              cmp_less;
    logic              cmp_equal;
    logic              cmp_greater;

    assign j_nxt = j + 1'b1;

    // Comparator sees the current adjacent pair only while sorting, zeros otherwise
    always_comb begin
        cmp_a = '0;
        cmp_b = '0;
        if (state == SORT) begin
            cmp_a = slot[j];
            cmp_b = slot[j_nxt];
        end
    end

    comparator u_cmp (
        .Data_in_A (cmp_a),
        .Data_in_B (cmp_b),
        .less      (cmp_less),
        .equal     (cmp_equal),
        .greater   (cmp_greater)
    );

    // Outputs decode registered state/indices only, so no input-to-output paths
    assign in_ready  = (state == IDLE) || (state == LOAD);
    assign busy      = (state == SORT) || (state == DRAIN);
    assign out_valid = (state == DRAIN);
    assign out_data  = (state == DRAIN) ? slot[ri] : '0;
    assign out_last  = (state == DRAIN) && (ri == LAST_IDX);

    // Sequencer: load, bubble passes with early exit, drain; flush overrides everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wi       <= '0;
            ri       <= '0;
            j        <= '0;
            p        <= '0;
            swapped  <= 1'b0;
            swap_cnt <= '0;
            for (int i = 0; i < N; i++) slot[i] <= '0;
        end else if (flush) begin
            state    <= IDLE;
            wi       <= '0;
            ri       <= '0;
            j        <= '0;
            p        <= '0;
            swapped  <= 1'b0;
            swap_cnt <= '0;
        end else begin
            case (state)
                IDLE, LOAD: begin
                    if (in_valid) begin
                        slot[wi] <= in_data;
                        wi       <= wi + 1'b1;
                        // a new block starts counting swaps from zero
                        if (state == IDLE) swap_cnt <= '0;
                        if (wi == LAST_IDX) begin
                            state   <= SORT;
                            j       <= '0;
                            p       <= '0;
                            swapped <= 1'b0;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                SORT: begin
                    // strictly greater only, so equal words keep their order
                    if (cmp_greater) begin
                        slot[j]     <= slot[j_nxt];
                        slot[j_nxt] <= slot[j];
                        swap_cnt    <= swap_cnt + 1'b1;
                    end
                    if (j == LAST_J - p) begin
                        if (!(swapped || cmp_greater) || (p == LAST_J)) begin
                            state <= DRAIN;
                            ri    <= '0;
                        end else begin
                            p       <= p + 1'b1;
                            j       <= '0;
                            swapped <= 1'b0;
                        end
                    end else begin
                        j       <= j_nxt;
                        swapped <= swapped | cmp_greater;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (ri == LAST_IDX) begin
                            state <= IDLE;
                            wi    <= '0;
                            ri    <= '0;
                        end else begin
                            ri <= ri + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The comparator must resolve every compare to exactly one relation
    a_cmp_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        (state == SORT) |-> $onehot({cmp_less, cmp_equal, cmp_greater}));

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Directed bench for cmp_sort_ctrl: load, sort timing, ordered drain, stalls, flush, reset.
// Latency: checks N-1 and N(N-1)/2 compare-cycle bounds for N=8.
// Backpressure: drives patterned out_ready stalls during drain.
module tb_cmp_sort_ctrl;

    typedef logic [3:0] blk_t [8];

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_ready;
    logic       out_last;
    logic       busy;
    logic [4:0] swap_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    cmp_sort_ctrl #(.N(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .swap_cnt  (swap_cnt)
    );

    // Present 8 words back-to-back, one per cycle, checking in_ready each time
    task automatic load_block(input blk_t v, input string name);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tests_run++;
            if (in_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL %s load in_ready word %0d: got %b want 1", name, i, in_ready);
            end
            in_valid = 1'b1;
            in_data  = v[i];
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 4'd0;
    endtask

    // Count SORT cycles until out_valid; exp_cycles < 0 skips the count check
    task automatic wait_sort(input int exp_cycles, input string name);
        int cyc = 0;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s sort_entry: in_ready=%b busy=%b want 0/1", name, in_ready, busy);
        end
        while (out_valid !== 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        tests_run++;
        if (cyc >= 100) begin
            tests_failed++;
            $display("FAIL %s sort_timeout: out_valid never rose", name);
        end else if (exp_cycles >= 0 && cyc != exp_cycles) begin
            tests_failed++;
            $display("FAIL %s sort_cycles: got %0d want %0d", name, cyc, exp_cycles);
        end
    endtask

    // Drain with out_ready from a pattern; every cycle the word must equal the next expected one
    task automatic drain_block(input blk_t e, input logic [15:0] rdy_pat,
                               input logic [4:0] exp_swaps, input string name);
        int   k   = 0;
        int   cyc = 0;
        logic exp_last;
        while (k < 8 && cyc < 200) begin
            exp_last = (k == 7);
            tests_run++;
            if ({out_valid, out_data, out_last} !== {1'b1, e[k], exp_last}) begin
                tests_failed++;
                $display("FAIL %s drain word %0d cyc %0d: valid=%b data=%0d last=%b want 1/%0d/%b",
                         name, k, cyc, out_valid, out_data, out_last, e[k], exp_last);
            end
            if (k == 7) begin
                tests_run++;
                if (swap_cnt !== exp_swaps) begin
                    tests_failed++;
                    $display("FAIL %s swap_cnt: got %0d want %0d", name, swap_cnt, exp_swaps);
                end
            end
            out_ready = rdy_pat[cyc % 16];
            @(posedge clk);
            if (out_ready) k++;
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        tests_run++;
        if (k < 8) begin
            tests_failed++;
            $display("FAIL %s drain_timeout: only %0d words", name, k);
        end else if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s post_drain: in_ready=%b out_valid=%b busy=%b want 1/0/0",
                     name, in_ready, out_valid, busy);
        end
    endtask

    task automatic test_reset();
        #12;
        tests_run++;
        if ({in_ready, out_valid, out_data, out_last, busy, swap_cnt} !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0}) begin
            tests_failed++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b out_data=%0d out_last=%b busy=%b swap_cnt=%0d",
                     in_ready, out_valid, out_data, out_last, busy, swap_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reverse();
        blk_t v = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
        blk_t e = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
        load_block(v, "reverse");
        wait_sort(28, "reverse");
        drain_block(e, 16'hFFFF, 5'd28, "reverse");
    endtask

    task automatic test_sorted();
        blk_t v = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
        load_block(v, "sorted");
        wait_sort(7, "sorted");
        drain_block(v, 16'hFFFF, 5'd0, "sorted");
    endtask

    // Duplicates plus downstream stalls; 14 strict inversions means equal pairs never swapped
    task automatic test_dups_stall();
        blk_t v = '{4'd10, 4'd12, 4'd15, 4'd11, 4'd10, 4'd10, 4'd3, 4'd15};
        blk_t e = '{4'd3, 4'd10, 4'd10, 4'd10, 4'd11, 4'd12, 4'd15, 4'd15};
        load_block(v, "dups_stall");
        wait_sort(-1, "dups_stall");
        drain_block(e, 16'b1001_0011_0110_0100, 5'd14, "dups_stall");
    endtask

    task automatic test_flush();
        blk_t v   = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
        blk_t alt = '{4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0};
        blk_t e   = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1};
        load_block(v, "flush");
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({in_ready, busy, out_valid, swap_cnt} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
            tests_failed++;
            $display("FAIL flush_mid_sort: in_ready=%b busy=%b out_valid=%b swap_cnt=%0d want 1/0/0/0",
                     in_ready, busy, out_valid, swap_cnt);
        end
        // flush together with a valid word: the word must not be stored
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'd15;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = 4'd0;
        load_block(alt, "flush_reload");
        wait_sort(-1, "flush_reload");
        drain_block(e, 16'hFFFF, 5'd10, "flush_reload");
    endtask

    task automatic test_reset_mid_drain();
        blk_t v = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
        load_block(v, "rst_drain");
        wait_sort(7, "rst_drain");
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, busy, out_data, out_last, swap_cnt} !== {1'b0, 1'b0, 4'd0, 1'b0, 5'd0}) begin
            tests_failed++;
            $display("FAIL rst_mid_drain: out_valid=%b busy=%b out_data=%0d out_last=%b swap_cnt=%0d",
                     out_valid, busy, out_data, out_last, swap_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    // Second block starts loading on the very cycle after the last output handshake
    task automatic test_back_to_back();
        blk_t a  = '{4'd10, 4'd12, 4'd15, 4'd11, 4'd10, 4'd10, 4'd3, 4'd15};
        blk_t ea = '{4'd3, 4'd10, 4'd10, 4'd10, 4'd11, 4'd12, 4'd15, 4'd15};
        blk_t b  = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
        blk_t eb = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
        load_block(a, "b2b_a");
        wait_sort(-1, "b2b_a");
        drain_block(ea, 16'hFFFF, 5'd14, "b2b_a");
        in_valid = 1'b1;
        in_data  = b[0];
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_first_accept busy: got %b want 0", busy);
        end
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            tests_run++;
            if (in_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL b2b_b load in_ready word %0d: got %b want 1", i, in_ready);
            end
            in_valid = 1'b1;
            in_data  = b[i];
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 4'd0;
        wait_sort(28, "b2b_b");
        drain_block(eb, 16'hFFFF, 5'd28, "b2b_b");
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        out_ready = 1'b1;
        test_reset();
        test_reverse();
        test_sorted();
        test_dups_stall();
        test_flush();
        test_reset_mid_drain();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
